sram_2168_ctl: RTL and testbench



---
 rtl/sram_2168_ctl_pkg.sv | 25 ++
 rtl/sram_2168_ctl_arb2.sv | 42 ++++
 rtl/sram_2168_ctl.sv | 164 ++++++++++++++++
 tb/tb_sram_2168_ctl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_2168_ctl_pkg.sv
// Shared types and limits for the 2168 SRAM sequencer/arbiter.
// Optional round-robin arbitration is selected by defining SRAM_CTL_RR_EN.
package sram_2168_ctl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StHold   = 2'd3
    } state_e;

    typedef enum logic {
        GntM0 = 1'b0,
        GntM1 = 1'b1
    } gnt_e;

    localparam int unsigned CntW    = 4;
    localparam int unsigned WaitMin = 1;
    localparam int unsigned WaitMax = 15;

    function automatic logic wait_in_range(input int unsigned w);
        return (w >= WaitMin) && (w <= WaitMax);
    endfunction

endpackage

// File: rtl/sram_2168_ctl_arb2.sv
// Two-way grant for the SRAM sequencer: fixed m0 priority, or round-robin on ties
// with a last_grant register when SRAM_CTL_RR_EN is defined.
module sram_arb2
    import sram_2168_ctl_pkg::*;
(
`ifdef SRAM_CTL_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
`endif
    input  logic req0,
    input  logic req1,
    output gnt_e gnt
);

`ifdef SRAM_CTL_RR_EN
    gnt_e last_grant_q;

    always_comb begin
        gnt = GntM0;
        if (req0 && req1) begin
            gnt = (last_grant_q == GntM0) ? GntM1 : GntM0;
        end else if (req1) begin
            gnt = GntM1;
        end
    end

    // Reset to m1 so the first tie after reset goes to m0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GntM1;
        end else if (grant_en) begin
            last_grant_q <= gnt;
        end
    end
`else
    always_comb begin
        gnt = (!req0 && req1) ? GntM1 : GntM0;
    end
`endif

endmodule

// File: rtl/sram_2168_ctl.sv
// Sequencer and 2-port arbiter for a ganged 2168 SRAM bank (IDLE/SETUP/ACCESS/HOLD).
// Define SRAM_CTL_RR_EN for round-robin arbitration on simultaneous requests.
module sram_2168_ctl
    import sram_2168_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_doe,
    input  logic [DATA_W-1:0] sram_din
);

    if (!wait_in_range(RD_WAIT) || !wait_in_range(WR_WAIT)) begin : g_bad_wait
        $error("sram_2168_ctl: RD_WAIT/WR_WAIT must be within 1..15");
    end

    state_e              state_q, state_d;
    gnt_e                gnt_q, gnt_d, gnt;
    logic                we_q, we_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                doe_q, doe_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                grant_en;

    sram_arb2 u_arb (
`ifdef SRAM_CTL_RR_EN
        .clk      (clk),
        .reset    (reset),
        .grant_en (grant_en),
`endif
        .req0     (m0_req),
        .req1     (m1_req),
        .gnt      (gnt)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_en = 1'b1;
                    gnt_d    = gnt;
                    state_d  = StSetup;
                    if (gnt == GntM1) begin
                        we_d   = m1_we;
                        addr_d = m1_addr;
                        dout_d = m1_wdata;
                    end else begin
                        we_d   = m0_we;
                        addr_d = m0_addr;
                        dout_d = m0_wdata;
                    end
                end
            end
            StSetup: begin
                cnt_d   = we_q ? CntW'(WR_WAIT) : CntW'(RD_WAIT);
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StHold;
                    ack0_d  = (gnt_q == GntM0);
                    ack1_d  = (gnt_q == GntM1);
                    if (!we_q) begin
                        if (gnt_q == GntM1) rdata1_d = sram_din;
                        else                rdata0_d = sram_din;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pad controls are registered from the next state so they align with it.
        ce_n_d = (state_d == StIdle);
        we_n_d = !((state_d == StAccess) && we_d);
        doe_d  = we_d && (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= GntM0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            doe_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            doe_q    <= doe_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_we_n = we_n_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_2168_ctl.sv
// Directed bench for sram_2168_ctl: behavioural 2168 bank, ack/we_n monitors, and a
// second instance with RD_WAIT=1/WR_WAIT=3. Honours SRAM_CTL_RR_EN for tie expectations.
`timescale 1ns/1ps
module tb_sram_2168_ctl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, sram_ce_n, sram_we_n, sram_doe;
    logic [15:0] m0_rdata, m1_rdata, sram_dout, sram_din;
    logic [11:0] sram_addr;

    sram_2168_ctl #(.ADDR_W(12), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
        .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din)
    );

    // Second instance: asymmetric wait states, m1 idle.
    logic        b_m0_req = 1'b0, b_m0_we = 1'b0, b_m1_req = 1'b0, b_m1_we = 1'b0;
    logic [11:0] b_m0_addr = '0, b_m1_addr = '0;
    logic [15:0] b_m0_wdata = '0, b_m1_wdata = '0;
    logic        b_m0_ack, b_m1_ack, b_ce_n, b_we_n, b_doe;
    logic [15:0] b_m0_rdata, b_m1_rdata, b_dout, b_din;
    logic [11:0] b_addr;

    sram_2168_ctl #(.ADDR_W(12), .DATA_W(16), .RD_WAIT(1), .WR_WAIT(3)) u_dut2 (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .sram_addr(b_addr), .sram_ce_n(b_ce_n), .sram_we_n(b_we_n),
        .sram_dout(b_dout), .sram_doe(b_doe), .sram_din(b_din)
    );

    // Bank model: content after reset is addr ^ 16'h5A00.
    logic [15:0] mem [4096];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'h5A00;
        end else if (!sram_ce_n && !sram_we_n && sram_doe) begin
            mem[sram_addr] <= sram_dout;
        end
    end
    assign sram_din = (!sram_ce_n && sram_we_n) ? mem[sram_addr] : 16'hDEAD;
    assign b_din    = (!b_ce_n && b_we_n) ? ~{4'h0, b_addr} : 16'hDEAD;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitors: one-hot ack, addr never moves around a low we_n, cycle tallies.
    logic [11:0] prev_addr;
    logic        prev_we_n;
    int we_low_total = 0, doe_total = 0, m0_ack_total = 0, b_we_low_total = 0;
    always @(negedge clk) begin
        if (!reset) begin
            check("ack_onehot", {31'b0, m0_ack & m1_ack}, 32'd0);
            if (sram_addr != prev_addr)
                check("addr_chg_we_n", {30'b0, prev_we_n, sram_we_n}, 32'd3);
        end
        prev_addr <= sram_addr;
        prev_we_n <= sram_we_n;
        if (!sram_we_n) we_low_total <= we_low_total + 1;
        if (sram_doe) doe_total <= doe_total + 1;
        if (m0_ack) m0_ack_total <= m0_ack_total + 1;
        if (!b_we_n) b_we_low_total <= b_we_low_total + 1;
    end

    task automatic access(input int m, input logic we, input logic [11:0] a,
                          input logic [15:0] d, output int lat, output logic [15:0] rd);
        repeat (2) @(negedge clk);
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
        lat = -1;
        rd  = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((m == 0) ? m0_ack : m1_ack) begin
                lat = i;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic access2(input logic we, input logic [11:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd);
        repeat (2) @(negedge clk);
        b_m0_req = 1'b1; b_m0_we = we; b_m0_addr = a; b_m0_wdata = d;
        lat = -1;
        rd  = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (b_m0_ack) begin
                lat = i;
                rd  = b_m0_rdata;
                break;
            end
        end
        b_m0_req = 1'b0;
    endtask

    initial begin
        int lat, t0, t1, n0, base_a, base_b, base_c;
        logic [15:0] rd, r0, r1, keep;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_we_doe", {29'b0, sram_ce_n, sram_we_n, sram_doe}, 32'd6);
        check("rst_addr", {20'b0, sram_addr}, 32'd0);
        check("rst_dout", {16'b0, sram_dout}, 32'd0);
        check("rst_acks", {30'b0, m0_ack, m1_ack}, 32'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
        reset = 1'b0;

        // 1: m0 write then read back, we_n/doe widths.
        base_a = we_low_total;
        base_b = doe_total;
        access(0, 1'b1, 12'h123, 16'hBEEF, lat, rd);
        repeat (3) @(posedge clk);
        check("t1_wr_lat", lat, 32'd4);
        check("t1_we_low_cycles", we_low_total - base_a, 32'd2);
        check("t1_doe_cycles", doe_total - base_b, 32'd4);
        check("t1_mem", {16'b0, mem[12'h123]}, 32'hBEEF);
        access(0, 1'b0, 12'h123, 16'h0000, lat, rd);
        check("t1_rd_lat", lat, 32'd4);
        check("t1_rd_data", {16'b0, rd}, 32'hBEEF);

        // 3: RD_WAIT=1 / WR_WAIT=3 instance.
        repeat (2) @(posedge clk);
        base_c = b_we_low_total;
        access2(1'b1, 12'h0AB, 16'h1234, lat, rd);
        check("t3_wr_lat", lat, 32'd5);
        access2(1'b0, 12'h0AB, 16'h0000, lat, rd);
        check("t3_rd_lat", lat, 32'd3);
        check("t3_rd_data", {16'b0, rd}, 32'hFF54);
        repeat (2) @(posedge clk);
        check("t3_we_low_cycles", b_we_low_total - base_c, 32'd3);

        // 2: simultaneous reads.
        repeat (2) @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h001;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h002;
        t0 = -1; t1 = -1; r0 = '0; r1 = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (m0_ack && t0 < 0) begin t0 = i; r0 = m0_rdata; m0_req = 1'b0; end
            if (m1_ack && t1 < 0) begin t1 = i; r1 = m1_rdata; m1_req = 1'b0; end
            if (t0 >= 0 && t1 >= 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
`ifdef SRAM_CTL_RR_EN
        check("t2_m1_first", t1, 32'd4);
        check("t2_m0_second", t0, 32'd9);
`else
        check("t2_m0_first", t0, 32'd4);
        check("t2_m1_second", t1, 32'd9);
`endif
        check("t2_m0_rdata", {16'b0, r0}, 32'h5A01);
        check("t2_m1_rdata", {16'b0, r1}, 32'h5A02);

        // 4: m0 streams reads, m1 wants a write.
        repeat (2) @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h010;
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'hFFF; m1_wdata = 16'h0001;
        n0 = 0; t1 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (m0_ack) n0++;
            if (m1_ack && t1 < 0) begin t1 = i; m1_req = 1'b0; end
        end
        m1_req = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (m0_ack) begin seen = 1'b1; break; end
        end
        m0_req = 1'b0;
        check("t4_m0_stop", {31'b0, seen}, 32'd1);
        check("t4_m0_rdata", {16'b0, m0_rdata}, 32'h5A10);
        repeat (2) @(posedge clk);
`ifdef SRAM_CTL_RR_EN
        check("t4_m1_served", t1, 32'd8);
        check("t4_m0_acks", n0, 32'd7);
        check("t4_mem", {16'b0, mem[12'hFFF]}, 32'h0001);
`else
        check("t4_m1_starved", t1, 32'hFFFF_FFFF);
        check("t4_m0_acks", n0, 32'd8);
        check("t4_mem", {16'b0, mem[12'hFFF]}, 32'h55FF);
`endif

        // 5: reset during the ACCESS phase of a write.
        repeat (2) @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h055; m0_wdata = 16'hAAAA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_in_access", {30'b0, sram_ce_n, sram_we_n}, 32'd0);
        reset = 1'b1;
        m0_req = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_pins", {29'b0, sram_ce_n, sram_we_n, sram_doe}, 32'd6);
        check("t5_rst_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) seen = 1'b1;
        end
        check("t5_no_ack", {31'b0, seen}, 32'd0);
        access(0, 1'b0, 12'h066, 16'h0000, lat, rd);
        check("t5_rd_lat", lat, 32'd4);
        check("t5_rd_data", {16'b0, rd}, 32'h5A66);

        // 6: m1 read leaves m0 untouched.
        repeat (2) @(posedge clk);
        keep = m0_rdata;
        base_a = m0_ack_total;
        access(1, 1'b0, 12'h3A0, 16'h0000, lat, rd);
        repeat (3) @(posedge clk);
        check("t6_rd_lat", lat, 32'd4);
        check("t6_rd_data", {16'b0, rd}, 32'h59A0);
        check("t6_m0_rdata", {16'b0, m0_rdata}, {16'b0, keep});
        check("t6_m0_rdata_val", {16'b0, m0_rdata}, 32'h5A66);
        check("t6_m0_no_ack", m0_ack_total - base_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
